// File: rtl/dm_read_arbiter_pkg.sv
// Shared definitions for the data-memory arbiters: bus widths, FSM state codes,
// access-size codes and the requester identity used by the round-robin logic.
package dm_read_arbiter_pkg;

    localparam int DOUBLEWORD_WIDTH = 64;
    localparam int DATA_MEMORY_SIZE = 1024;
    localparam int ADDR_WIDTH_DM    = $clog2(DATA_MEMORY_SIZE);
    localparam int DATA_TYPE_WIDTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } arb_state_t;

    // Access-size codes, passed through untouched to the memory handler.
    typedef enum logic [DATA_TYPE_WIDTH-1:0] {
        DT_BYTE   = 2'd0,
        DT_HALF   = 2'd1,
        DT_WORD   = 2'd2,
        DT_DOUBLE = 2'd3
    } data_type_t;

    typedef enum logic {
        GNT_P1 = 1'b0,
        GNT_P2 = 1'b1
    } grant_t;

    function automatic grant_t other_grant(input grant_t g);
        return (g == GNT_P1) ? GNT_P2 : GNT_P1;
    endfunction

endpackage

// File: rtl/dm_read_arbiter_if.sv
// Read-side bus bundle between the two processor load units, the arbiter and
// the data-memory read handler. The arbiter uses the master view.
interface dm_read_arbiter_if;
    import dm_read_arbiter_pkg::*;

    logic [DOUBLEWORD_WIDTH-1:0] data_bus_rd_dm;
    logic [ADDR_WIDTH_DM-1:0]    addr_rd_dm;
    logic [DATA_TYPE_WIDTH-1:0]  data_type_rd_dm;
    logic                        rd_idle_dm;
    logic                        rd_ins_dm;

    logic [ADDR_WIDTH_DM-1:0]    addr_rd_p1;
    logic [DATA_TYPE_WIDTH-1:0]  data_type_rd_p1;
    logic                        rd_ins_p1;
    logic                        rd_access_p1;
    logic                        rd_idle_p1;
    logic                        rd_valid_p1;
    logic [DOUBLEWORD_WIDTH-1:0] data_bus_rd_p1;

    logic [ADDR_WIDTH_DM-1:0]    addr_rd_p2;
    logic [DATA_TYPE_WIDTH-1:0]  data_type_rd_p2;
    logic                        rd_ins_p2;
    logic                        rd_access_p2;
    logic                        rd_idle_p2;
    logic                        rd_valid_p2;
    logic [DOUBLEWORD_WIDTH-1:0] data_bus_rd_p2;

    modport master (
        input  data_bus_rd_dm, rd_idle_dm,
        output addr_rd_dm, data_type_rd_dm, rd_ins_dm,
        input  addr_rd_p1, data_type_rd_p1, rd_ins_p1,
        output rd_access_p1, rd_idle_p1, rd_valid_p1, data_bus_rd_p1,
        input  addr_rd_p2, data_type_rd_p2, rd_ins_p2,
        output rd_access_p2, rd_idle_p2, rd_valid_p2, data_bus_rd_p2
    );

    modport slave (
        output data_bus_rd_dm, rd_idle_dm,
        input  addr_rd_dm, data_type_rd_dm, rd_ins_dm,
        output addr_rd_p1, data_type_rd_p1, rd_ins_p1,
        input  rd_access_p1, rd_idle_p1, rd_valid_p1, data_bus_rd_p1,
        output addr_rd_p2, data_type_rd_p2, rd_ins_p2,
        input  rd_access_p2, rd_idle_p2, rd_valid_p2, data_bus_rd_p2
    );

endinterface

// File: rtl/dm_read_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: on a tie the requester that did not win last
// time is chosen. Purely combinational so the write arbiter can reuse it.
module rr_arbiter2
    import dm_read_arbiter_pkg::*;
(
    input  logic   req_p1,
    input  logic   req_p2,
    input  grant_t last_grant,
    output logic   gnt_valid,
    output grant_t gnt
);

    always_comb begin
        gnt_valid = req_p1 | req_p2;
        gnt       = GNT_P1;
        if (req_p1 && req_p2) begin
            gnt = other_grant(last_grant);
        end else if (req_p2) begin
            gnt = GNT_P2;
        end
    end

endmodule

// File: rtl/dm_read_arbiter.sv
// Multiplexes two processors' read requests onto the single data-memory read
// handler and routes each returned doubleword back to the requester.
//
// state | meaning
// IDLE  | no read owned; arbitrate pending requests
// REQ   | rd_ins_dm asserted, waiting for the handler to drop rd_idle_dm
// BUSY  | handler working; complete when rd_idle_dm returns high
module dm_read_arbiter
    import dm_read_arbiter_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    dm_read_arbiter_if.master bus
);

    arb_state_t state_q, state_d;
    grant_t     last_grant_q;
    grant_t     gnt;
    logic       gnt_valid;
    logic       grant_en;
    logic       complete_en;
    logic       abort_en;
    logic       rd_ins_dm_c;

    logic                        access_p1_q, access_p2_q;
    logic                        valid_p1_q, valid_p2_q;
    logic [ADDR_WIDTH_DM-1:0]    addr_q;
    logic [DATA_TYPE_WIDTH-1:0]  type_q;
    logic [DOUBLEWORD_WIDTH-1:0] data_p1_q, data_p2_q;

    rr_arbiter2 u_rr (
        .req_p1     (bus.rd_ins_p1),
        .req_p2     (bus.rd_ins_p2),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt        (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_en    = 1'b0;
        complete_en = 1'b0;
        abort_en    = 1'b0;
        rd_ins_dm_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    grant_en = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                rd_ins_dm_c = 1'b1;
                if (!bus.rd_idle_dm) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.rd_idle_dm) begin
                    complete_en = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                abort_en = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // The owner of an in-flight read is always last_grant_q, set at grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GNT_P2;
            access_p1_q  <= 1'b0;
            access_p2_q  <= 1'b0;
            valid_p1_q   <= 1'b0;
            valid_p2_q   <= 1'b0;
            addr_q       <= '0;
            type_q       <= '0;
            data_p1_q    <= '0;
            data_p2_q    <= '0;
        end else begin
            valid_p1_q <= 1'b0;
            valid_p2_q <= 1'b0;
            if (grant_en) begin
                last_grant_q <= gnt;
                access_p1_q  <= (gnt == GNT_P1);
                access_p2_q  <= (gnt == GNT_P2);
                addr_q       <= (gnt == GNT_P1) ? bus.addr_rd_p1 : bus.addr_rd_p2;
                type_q       <= (gnt == GNT_P1) ? bus.data_type_rd_p1 : bus.data_type_rd_p2;
            end
            if (complete_en) begin
                access_p1_q <= 1'b0;
                access_p2_q <= 1'b0;
                if (last_grant_q == GNT_P1) begin
                    data_p1_q  <= bus.data_bus_rd_dm;
                    valid_p1_q <= 1'b1;
                end else begin
                    data_p2_q  <= bus.data_bus_rd_dm;
                    valid_p2_q <= 1'b1;
                end
            end
            if (abort_en) begin
                access_p1_q <= 1'b0;
                access_p2_q <= 1'b0;
            end
        end
    end

    assign bus.rd_ins_dm       = rd_ins_dm_c;
    assign bus.addr_rd_dm      = addr_q;
    assign bus.data_type_rd_dm = type_q;

    assign bus.rd_access_p1   = access_p1_q;
    assign bus.rd_idle_p1     = ~access_p1_q;
    assign bus.rd_valid_p1    = valid_p1_q;
    assign bus.data_bus_rd_p1 = data_p1_q;

    assign bus.rd_access_p2   = access_p2_q;
    assign bus.rd_idle_p2     = ~access_p2_q;
    assign bus.rd_valid_p2    = valid_p2_q;
    assign bus.data_bus_rd_p2 = data_p2_q;

endmodule

// File: tb/tb_dm_read_arbiter.sv
// Bench for dm_read_arbiter: directed scenarios plus random two-requester
// traffic against a transaction-level model of who owns the memory and what it returns.
module tb_dm_read_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dm_read_arbiter_if bus ();

    dm_read_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [63:0] mem_word [1024];

    // stimulus drive values, applied just before each rising edge
    bit          req1, req2;
    logic [9:0]  addr1, addr2;
    logic [1:0]  type1, type2;
    bit          idle_drv;
    logic [63:0] data_drv;
    int          cfg_wait, cfg_busy;
    bit          outstanding1, outstanding2;

    // reference model: owner 0 = nobody, 1 = P1, 2 = P2
    int          m_owner, m_last;
    logic [9:0]  m_addr;
    logic [1:0]  m_type;
    logic [63:0] exp_data1, exp_data2;
    bit          exp_v1, exp_v2;
    bit          mem_dropped;
    int          mem_wait, mem_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = 0; m_last = 2; m_addr = '0; m_type = '0;
        exp_data1 = '0; exp_data2 = '0; exp_v1 = 0; exp_v2 = 0;
        mem_dropped = 0; mem_wait = 0; mem_busy = 0;
        req1 = 0; req2 = 0; idle_drv = 1; data_drv = '0;
        outstanding1 = 0; outstanding2 = 0;
    endtask

    task automatic apply_drives();
        bus.rd_ins_p1 = req1; bus.addr_rd_p1 = addr1; bus.data_type_rd_p1 = type1;
        bus.rd_ins_p2 = req2; bus.addr_rd_p2 = addr2; bus.data_type_rd_p2 = type2;
        bus.rd_idle_dm = idle_drv; bus.data_bus_rd_dm = data_drv;
    endtask

    // One clock: drive, predict the coming edge, sample at the falling edge, react.
    task automatic cycle();
        int g;
        apply_drives();
        exp_v1 = 0; exp_v2 = 0;
        if (m_owner == 0) begin
            if (req1 || req2) begin
                g = (req1 && req2) ? ((m_last == 1) ? 2 : 1) : (req1 ? 1 : 2);
                m_owner = g; m_last = g;
                m_addr = (g == 1) ? addr1 : addr2;
                m_type = (g == 1) ? type1 : type2;
                mem_dropped = 0; mem_wait = cfg_wait; mem_busy = cfg_busy;
            end
        end else if (mem_dropped && idle_drv) begin
            if (m_owner == 1) begin exp_data1 = mem_word[m_addr]; exp_v1 = 1; end
            else              begin exp_data2 = mem_word[m_addr]; exp_v2 = 1; end
            m_owner = 0;
        end
        @(negedge clk);
        chk("access_p1", bus.rd_access_p1, m_owner == 1);
        chk("access_p2", bus.rd_access_p2, m_owner == 2);
        chk("idle_p1",   bus.rd_idle_p1,   m_owner != 1);
        chk("idle_p2",   bus.rd_idle_p2,   m_owner != 2);
        chk("valid_p1",  bus.rd_valid_p1,  exp_v1);
        chk("valid_p2",  bus.rd_valid_p2,  exp_v2);
        chk("data_p1",   bus.data_bus_rd_p1, exp_data1);
        chk("data_p2",   bus.data_bus_rd_p2, exp_data2);
        chk("rd_ins_dm", bus.rd_ins_dm, (m_owner != 0) && !mem_dropped);
        chk("addr_dm",   bus.addr_rd_dm, m_addr);
        chk("type_dm",   bus.data_type_rd_dm, m_type);
        // requesters drop on grant and are free to scribble on their address
        if (bus.rd_access_p1 && req1) begin req1 = 0; addr1 = 10'($urandom); type1 = 2'($urandom); end
        if (bus.rd_access_p2 && req2) begin req2 = 0; addr2 = 10'($urandom); type2 = 2'($urandom); end
        if (bus.rd_valid_p1) outstanding1 = 0;
        if (bus.rd_valid_p2) outstanding2 = 0;
        if (m_owner != 0 && !mem_dropped) begin
            if (mem_wait == 0) begin
                idle_drv = 0; mem_dropped = 1; data_drv = {$urandom, $urandom};
            end else mem_wait--;
        end else if (m_owner != 0 && !idle_drv) begin
            if (mem_busy == 0) begin
                idle_drv = 1; data_drv = mem_word[bus.addr_rd_dm];
            end else mem_busy--;
        end
    endtask

    task automatic run_until_quiet(input int budget);
        int i = 0;
        while ((m_owner != 0 || req1 || req2) && i < budget) begin
            cycle();
            i++;
        end
        chk("quiet_within_budget", i < budget, 1'b1);
    endtask

    task automatic apply_reset();
        rst_n = 0;
        #1;
        chk("rst_access_p1", bus.rd_access_p1, 0);
        chk("rst_access_p2", bus.rd_access_p2, 0);
        chk("rst_valid_p1",  bus.rd_valid_p1, 0);
        chk("rst_valid_p2",  bus.rd_valid_p2, 0);
        chk("rst_idle_p1",   bus.rd_idle_p1, 1);
        chk("rst_idle_p2",   bus.rd_idle_p2, 1);
        chk("rst_rd_ins_dm", bus.rd_ins_dm, 0);
        chk("rst_addr_dm",   bus.addr_rd_dm, 0);
        chk("rst_data_p1",   bus.data_bus_rd_p1, 0);
        chk("rst_data_p2",   bus.data_bus_rd_p2, 0);
        model_reset();
        apply_drives();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_word[i] = {$urandom, $urandom};
        addr1 = '0; addr2 = '0; type1 = '0; type2 = '0;
        cfg_wait = 0; cfg_busy = 0;
        model_reset();
        apply_drives();
        #2;
        apply_reset();

        // single read by P1
        mem_word[10'h010] = 64'hDEADBEEF_CAFEF00D;
        cfg_wait = 2; cfg_busy = 1;
        req1 = 1; addr1 = 10'h010; type1 = 2'd3;
        cycle();
        chk("single_grant", bus.rd_access_p1, 1);
        chk("single_addr", bus.addr_rd_dm, 10'h010);
        run_until_quiet(100);
        chk("single_data", bus.data_bus_rd_p1, 64'hDEADBEEF_CAFEF00D);
        chk("single_p2_untouched", bus.data_bus_rd_p2, 0);

        // simultaneous requests from reset, then a second tied pair
        apply_reset();
        cfg_wait = 1; cfg_busy = 0;
        req1 = 1; addr1 = 10'h004; req2 = 1; addr2 = 10'h008;
        cycle();
        chk("tie_first_p1", bus.rd_access_p1, 1);
        run_until_quiet(100);
        chk("tie_data_p1", bus.data_bus_rd_p1, mem_word[10'h004]);
        chk("tie_data_p2", bus.data_bus_rd_p2, mem_word[10'h008]);
        req1 = 1; req2 = 1;
        cycle();
        chk("tie_third_p1", bus.rd_access_p1, 1);
        run_until_quiet(100);

        // address change after grant
        cfg_wait = 3; cfg_busy = 2;
        req2 = 1; addr2 = 10'h020;
        cycle();
        addr2 = 10'h3FF;
        for (int i = 0; i < 3; i++) cycle();
        chk("addr_hold", bus.addr_rd_dm, 10'h020);
        run_until_quiet(100);
        chk("addr_hold_data", bus.data_bus_rd_p2, mem_word[10'h020]);

        // slow memory keeps the request up
        cfg_wait = 10; cfg_busy = 0;
        req1 = 1; addr1 = 10'h155;
        cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("slow_rd_ins", bus.rd_ins_dm, 1);
            chk("slow_idle_p1", bus.rd_idle_p1, 0);
        end
        run_until_quiet(100);

        // reset while the handler is busy
        cfg_wait = 0; cfg_busy = 5;
        req1 = 1; addr1 = 10'h0AA;
        cycle();
        cycle();
        chk("midbusy_in_busy", bus.rd_access_p1 && !bus.rd_ins_dm, 1);
        apply_reset();
        cfg_wait = 1; cfg_busy = 1;
        req1 = 1; addr1 = 10'h0AB;
        run_until_quiet(100);
        chk("after_reset_data", bus.data_bus_rd_p1, mem_word[10'h0AB]);

        // data hold across the other requester's completion
        mem_word[10'h040] = 64'h1234;
        mem_word[10'h080] = 64'h5678;
        req1 = 1; addr1 = 10'h040;
        run_until_quiet(100);
        req2 = 1; addr2 = 10'h080;
        run_until_quiet(100);
        chk("hold_p1", bus.data_bus_rd_p1, 64'h1234);
        chk("hold_p2", bus.data_bus_rd_p2, 64'h5678);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            cfg_wait = $urandom_range(0, 4);
            cfg_busy = $urandom_range(0, 3);
            if (!req1 && !outstanding1 && $urandom_range(0, 3) == 0) begin
                req1 = 1; outstanding1 = 1; addr1 = 10'($urandom); type1 = 2'($urandom);
            end
            if (!req2 && !outstanding2 && $urandom_range(0, 3) == 0) begin
                req2 = 1; outstanding2 = 1; addr2 = 10'($urandom); type2 = 2'($urandom);
            end
            cycle();
        end
        run_until_quiet(200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
